// File: rtl/riscv_dram_burst_model_if.sv
// riscv_dram_burst_model_if: line-memory request/completion bus.
// master (cache side): drives wren, rden, addr, data_in; observes data_out, mem_ready, mem_busy, addr_err.
// slave (memory side): the mirror image.
interface riscv_dram_burst_model_if #(
  parameter int S_ADDR     = 23,
  parameter int DATA_WIDTH = 128
);
  logic                  wren;
  logic                  rden;
  logic [S_ADDR-1:0]     addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  mem_ready;
  logic                  mem_busy;
  logic                  addr_err;
  modport master (output wren, rden, addr, data_in, input data_out, mem_ready, mem_busy, addr_err);
  modport slave  (input wren, rden, addr, data_in, output data_out, mem_ready, mem_busy, addr_err);
endinterface

// File: rtl/riscv_dram_burst_model.sv
// riscv_dram_burst_model: line-granular main memory with independent read/write latency and range check.
// Ports: clk (rising edge), rst_n (sync, active-low), bus (slave side of riscv_dram_burst_model_if).
module riscv_dram_burst_model #(
  parameter int DATA_WIDTH = 128,
  parameter int DATAPBLOCK = 16,
  parameter int MEM_SIZE   = 4096,
  parameter int S_ADDR     = 23,
  parameter int RD_LATENCY = 4,
  parameter int WR_LATENCY = 4,
  parameter int DEPTH      = MEM_SIZE / DATAPBLOCK
) (
  input logic                      clk,
  input logic                      rst_n,
  riscv_dram_burst_model_if.slave  bus
);
  localparam int AW     = $clog2(DEPTH);
  localparam int MAXLAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CW     = $clog2(MAXLAT) + 1;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t                r_state, w_next;
  logic [CW-1:0]         r_cnt, w_cnt, w_lat;
  logic                  r_wr, r_err;
  logic [S_ADDR-1:0]     r_addr;
  logic [DATA_WIDTH-1:0] r_data, r_dout;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  w_idle, w_req, w_fire, w_wr, w_oob;
  logic [S_ADDR-1:0]     w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  assign w_idle = (r_state == IDLE);
  assign w_req  = bus.wren | bus.rden;
  assign w_lat  = bus.wren ? CW'(WR_LATENCY - 1) : CW'(RD_LATENCY - 1);
  // A latency-1 op completes on its acceptance edge, before the latches hold it,
  // so the array access looks through to the live request while idle.
  assign w_wr   = w_idle ? bus.wren    : r_wr;
  assign w_addr = w_idle ? bus.addr    : r_addr;
  assign w_data = w_idle ? bus.data_in : r_data;
  assign w_oob  = |w_addr[S_ADDR-1:AW];
  assign w_fire = (w_next == DONE);
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    if (w_idle) begin
      if (w_req) begin
        w_cnt  = w_lat;
        w_next = (w_lat == '0) ? DONE : WAIT;
      end
    end else if (r_state == WAIT) begin
      w_cnt  = r_cnt - 1'b1;
      w_next = (r_cnt == CW'(1)) ? DONE : WAIT;
    end else begin
      w_next = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_err   <= w_fire & w_oob;
      if (w_fire && !w_wr && !w_oob) r_dout <= r_mem[w_addr[AW-1:0]];
    end
  end
  always_ff @(posedge clk) begin
    if (w_idle && w_req) begin
      r_wr   <= bus.wren;
      r_addr <= bus.addr;
      r_data <= bus.data_in;
    end
  end
  // Reset takes priority so an aborted write never lands, but contents survive reset.
  always_ff @(posedge clk) begin
    if (rst_n && w_fire && w_wr && !w_oob) r_mem[w_addr[AW-1:0]] <= w_data;
  end
  assign bus.mem_ready = (r_state == DONE);
  assign bus.mem_busy  = !w_idle;
  assign bus.addr_err  = r_err;
  assign bus.data_out  = r_dout;
endmodule

// File: tb/tb_riscv_dram_burst_model.sv
// tb_riscv_dram_burst_model: directed scoreboard bench for two latency configurations.
module tb_riscv_dram_burst_model;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {int lat; logic err; logic [127:0] d;} exp_t;
  exp_t sb[$];
  logic [127:0] ma [256];
  logic [127:0] mb [256];
  logic [127:0] lo_a = '0;
  logic [127:0] lo_b = '0;
  always #5 clk = ~clk;
  riscv_dram_burst_model_if #(.S_ADDR(23), .DATA_WIDTH(128)) ia ();
  riscv_dram_burst_model_if #(.S_ADDR(23), .DATA_WIDTH(128)) ib ();
  riscv_dram_burst_model #(.RD_LATENCY(4), .WR_LATENCY(4)) u_a (.clk(clk), .rst_n(rst_a), .bus(ia));
  riscv_dram_burst_model #(.RD_LATENCY(1), .WR_LATENCY(7)) u_b (.clk(clk), .rst_n(rst_b), .bus(ib));
  function automatic logic rdy(input bit b);
    return b ? ib.mem_ready : ia.mem_ready;
  endfunction
  function automatic logic bsy(input bit b);
    return b ? ib.mem_busy : ia.mem_busy;
  endfunction
  function automatic logic er(input bit b);
    return b ? ib.addr_err : ia.addr_err;
  endfunction
  function automatic logic [127:0] dout(input bit b);
    return b ? ib.data_out : ia.data_out;
  endfunction
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drive(input bit b, input logic w, input logic r, input logic [22:0] a, input logic [127:0] d);
    if (b) begin
      ib.wren = w; ib.rden = r; ib.addr = a; ib.data_in = d;
    end else begin
      ia.wren = w; ia.rden = r; ia.addr = a; ia.data_in = d;
    end
  endtask
  function automatic void expect_op(input bit b, input logic w, input logic [22:0] a, input logic [127:0] d);
    exp_t e;
    e.err = (a[22:8] != '0);
    e.lat = b ? (w ? 7 : 1) : 4;
    if (!e.err) begin
      if (w) begin
        if (b) mb[a[7:0]] = d; else ma[a[7:0]] = d;
      end else begin
        if (b) lo_b = mb[a[7:0]]; else lo_a = ma[a[7:0]];
      end
    end
    e.d = b ? lo_b : lo_a;
    sb.push_back(e);
  endfunction
  task automatic finish_op(input bit b, input bit stray, input bit hold, input logic [22:0] ha, input logic [127:0] hd);
    int n = 1;
    int nb = 0;
    exp_t e;
    while (!rdy(b) && n < 30) begin
      nb += int'(bsy(b));
      if (stray) drive(b, n % 2 == 1, n % 2 == 0, (n % 2 == 1) ? 23'd5 : 23'd3, {4{$urandom}});
      @(posedge clk); #1;
      n++;
    end
    nb += int'(bsy(b));
    if (hold) drive(b, 1'b1, 1'b0, ha, hd); else drive(b, 1'b0, 1'b0, '0, '0);
    e = sb.pop_front();
    chk("latency", n, e.lat);
    chk("busy_cycles", nb, e.lat);
    chk("addr_err", er(b), e.err);
    chk("data_out", dout(b), e.d);
    @(posedge clk); #1;
    chk("ready_pulse", rdy(b), 1'b0);
    chk("busy_after", bsy(b), 1'b0);
  endtask
  task automatic issue(input bit b, input logic w, input logic r, input logic [22:0] a, input logic [127:0] d,
                       input bit stray = 0, input bit hold = 0, input logic [22:0] ha = '0, input logic [127:0] hd = '0);
    drive(b, w, r, a, d);
    expect_op(b, w, a, d);
    @(posedge clk); #1;
    drive(b, 1'b0, 1'b0, '0, '0);
    finish_op(b, stray, hold, ha, hd);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: no summary reached");
    $fatal(1);
  end
  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", rdy(k[0]), 1'b0);
      chk("rst_busy", bsy(k[0]), 1'b0);
      chk("rst_err", er(k[0]), 1'b0);
      chk("rst_dout", dout(k[0]), '0);
    end
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    issue(0, 1'b1, 1'b0, 23'd5, 128'hDEADBEEF_0123);
    issue(0, 1'b0, 1'b1, 23'd5, '0);
    issue(0, 1'b1, 1'b0, 23'd0, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
    issue(0, 1'b1, 1'b0, 23'd256, 128'hBAD0_BAD0_BAD0);
    issue(0, 1'b0, 1'b1, 23'd0, '0);
    issue(0, 1'b0, 1'b1, 23'd300, '0);
    issue(0, 1'b0, 1'b1, 23'd5, '0, 1'b1, 1'b1, 23'd11, 128'hCAFEF00D_1111_2222);
    expect_op(0, 1'b1, 23'd11, 128'hCAFEF00D_1111_2222);
    @(posedge clk); #1;
    chk("held_accept", ia.mem_busy, 1'b1);
    drive(0, 1'b0, 1'b0, '0, '0);
    finish_op(0, 1'b0, 1'b0, '0, '0);
    issue(0, 1'b0, 1'b1, 23'd11, '0);
    issue(0, 1'b0, 1'b1, 23'd5, '0);
    issue(0, 1'b1, 1'b0, 23'd9, 128'h0000_0001_AAAA_5555);
    issue(0, 1'b0, 1'b1, 23'd9, '0);
    drive(0, 1'b1, 1'b0, 23'd9, 128'h9999_8888_7777_6666);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ready", ia.mem_ready, 1'b0);
    chk("midrst_busy", ia.mem_busy, 1'b0);
    chk("midrst_err", ia.addr_err, 1'b0);
    chk("midrst_dout", ia.data_out, '0);
    lo_a = '0;
    rst_a = 1'b1;
    @(posedge clk); #1;
    issue(0, 1'b0, 1'b1, 23'd9, '0);
    issue(1, 1'b1, 1'b0, 23'd20, 128'h7777_0000_1234_5678);
    issue(1, 1'b0, 1'b1, 23'd20, '0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_stable", ib.data_out, lo_b);
    end
    issue(1, 1'b1, 1'b1, 23'd3, 128'h3333_ABCD_0000_EEEE);
    issue(1, 1'b0, 1'b1, 23'd3, '0);
    issue(1, 1'b0, 1'b1, 23'd400, '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
